gcd_engine_param: RTL

- Parametrised, clocked GCD engine; successor to the fixed 5-bit next_GCD.
- Accepts two unsigned WIDTH-bit operands on a Go/Done four-phase handshake.
- Computes the GCD iteratively, by subtractive Euclid or binary (Stein), selected by parameter.
- Reports the result, a zero-operand error and an iteration count; sits in the arithmetic datapath beside the multiplier.

---
 rtl/gcd_engine_param.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/gcd_engine_param.sv
// gcd_engine_param
//   Clocked, parametrised GCD engine on a Go/Done four-phase handshake.
//   Subtractive Euclid (MODE=0) or binary Stein (MODE=1).
//
// Ports
//   Clk      in   rising-edge clock
//   Rst_n    in   asynchronous active-low reset
//   X, Y     in   operands, sampled only on the Go-accept edge
//   Go       in   start request, held high until Done is seen
//   Done     out  result valid, held until Go drops
//   Busy     out  high while iterating
//   Gcd      out  result, stable while Done=1
//   Zero_err out  both operands were zero
//   Cycles   out  iterations used, saturating at all-ones
//
// state | meaning
// IDLE  | waiting for Go, outputs hold last result
// CALC  | one algorithm step per cycle
// DONE  | result presented, waiting for Go low

module gcd_engine_param #(
    parameter int WIDTH = 5,
    parameter int MODE  = 0,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Go,
    output logic             Done,
    output logic             Busy,
    output logic [WIDTH-1:0] Gcd,
    output logic             Zero_err,
    output logic [CNT_W-1:0] Cycles
);

    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             zero_err_q, zero_err_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic             a_eq_b;
    logic             a_gt_b;

    assign a_eq_b = (a_q == b_q);
    assign a_gt_b = (a_q > b_q);

    // State and datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            gcd_q      <= '0;
            zero_err_q <= 1'b0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            k_q        <= k_d;
            gcd_q      <= gcd_d;
            zero_err_q <= zero_err_d;
            cycles_q   <= cycles_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Go) begin
                    if (X == '0 || Y == '0) state_d = DONE;
                    else                    state_d = CALC;
                end
            end
            CALC: begin
                if (a_eq_b) state_d = DONE;
            end
            DONE: begin
                if (!Go) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        k_d        = k_q;
        gcd_d      = gcd_q;
        zero_err_d = zero_err_q;
        cycles_d   = cycles_q;
        case (state_q)
            IDLE: begin
                if (Go) begin
                    cycles_d = '0;
                    if (X == '0 && Y == '0) begin
                        gcd_d      = '0;
                        zero_err_d = 1'b1;
                    end else if (X == '0) begin
                        gcd_d      = Y;
                        zero_err_d = 1'b0;
                    end else if (Y == '0) begin
                        gcd_d      = X;
                        zero_err_d = 1'b0;
                    end else begin
                        a_d        = X;
                        b_d        = Y;
                        k_d        = '0;
                        zero_err_d = 1'b0;
                    end
                end
            end
            CALC: begin
                if (cycles_q != {CNT_W{1'b1}}) cycles_d = cycles_q + CNT_W'(1);
                if (MODE == 0) begin
                    if (a_eq_b)      gcd_d = a_q;
                    else if (a_gt_b) a_d   = a_q - b_q;
                    else             b_d   = b_q - a_q;
                end else begin
                    // The shift never loses bits: the result is at most min(X,Y).
                    if (a_eq_b) begin
                        gcd_d = a_q << k_q;
                    end else if (!a_q[0] && !b_q[0]) begin
                        a_d = a_q >> 1;
                        b_d = b_q >> 1;
                        k_d = k_q + KW'(1);
                    end else if (!a_q[0]) begin
                        a_d = a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_d = b_q >> 1;
                    end else if (a_gt_b) begin
                        a_d = a_q - b_q;
                    end else begin
                        b_d = b_q - a_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        Done     = (state_q == DONE);
        Busy     = (state_q == CALC);
        Gcd      = gcd_q;
        Zero_err = zero_err_q;
        Cycles   = cycles_q;
    end

endmodule
